sensor_conditioner: RTL

Front-end conditioning stage for the intersection controller. It takes the three raw loop-detector inputs and drives the S1/S2/S3 vehicle-request inputs of the traffic-light FSM. Each channel is synchronized, debounced, and held as a latched call until its approach is served. A detector stuck asserted is flagged as a fault, and its request is forced on (max recall) so that approach is never starved.

---
 rtl/sensor_conditioner.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sensor_conditioner.sv
// Loop-detector front end: per-channel synchronizer, debounce filter, call latch
// and stuck-sensor recall feeding the S1..S3 request inputs of the light FSM.
module sensor_conditioner #(
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned STUCK_CYC    = 1024
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       R1,
    input  logic       R2,
    input  logic       R3,
    input  logic [1:0] L1,
    input  logic [1:0] L2,
    input  logic [1:0] L3,
    output logic       S1,
    output logic       S2,
    output logic       S3,
    output logic [2:0] Stuck,
    output logic       Fault
);

    localparam int unsigned NUM_CH  = 3;
    localparam int unsigned DCNT_W  = 8;
    localparam int unsigned SCNT_W  = 16;

    localparam logic [1:0]        LIGHT_GREEN = 2'b01;
    localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [SCNT_W-1:0] SCNT_MAX    = SCNT_W'(STUCK_CYC);
    localparam logic [SCNT_W-1:0] SCNT_LAST   = SCNT_W'(STUCK_CYC - 1);

    logic [NUM_CH-1:0] raw;
    logic [1:0]        light [NUM_CH];
    logic [NUM_CH-1:0] stuck_vec;
    logic [NUM_CH-1:0] req_vec;
    logic              fault_q;

    assign raw      = {R3, R2, R1};
    assign light[0] = L1;
    assign light[1] = L2;
    assign light[2] = L3;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic              sync1;
        logic              sync2;
        logic              filt;
        logic              call;
        logic              stuck;
        logic              req;
        logic [DCNT_W-1:0] dcnt;
        logic [SCNT_W-1:0] scnt;

        logic              filt_nxt;
        logic              call_nxt;
        logic              stuck_nxt;
        logic [DCNT_W-1:0] dcnt_nxt;
        logic [SCNT_W-1:0] scnt_nxt;

        // Debounce, call latch (service clear wins over a new call) and stuck counter
        always_comb begin
            filt_nxt  = filt;
            dcnt_nxt  = '0;
            call_nxt  = call;
            scnt_nxt  = '0;
            stuck_nxt = stuck;

            if (sync2 != filt) begin
                if (dcnt == DCNT_LAST) begin
                    filt_nxt = sync2;
                end else begin
                    dcnt_nxt = dcnt + DCNT_W'(1);
                end
            end

            if (light[n] == LIGHT_GREEN) begin
                call_nxt = 1'b0;
            end else if (filt_nxt && !filt) begin
                call_nxt = 1'b1;
            end

            if (filt) begin
                scnt_nxt = (scnt == SCNT_MAX) ? scnt : scnt + SCNT_W'(1);
                if (scnt == SCNT_LAST) begin
                    stuck_nxt = 1'b1;
                end
            end
        end

        always_ff @(posedge Clock or negedge Reset) begin
            if (!Reset) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
                filt  <= 1'b0;
                dcnt  <= '0;
                call  <= 1'b0;
                scnt  <= '0;
                stuck <= 1'b0;
                req   <= 1'b0;
            end else begin
                sync1 <= raw[n];
                sync2 <= sync1;
                filt  <= filt_nxt;
                dcnt  <= dcnt_nxt;
                call  <= call_nxt;
                scnt  <= scnt_nxt;
                stuck <= stuck_nxt;
                req   <= filt | call | stuck;
            end
        end

        assign stuck_vec[n] = stuck;
        assign req_vec[n]   = req;
    end

    // Fault lags the stuck flags by one edge
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= |stuck_vec;
        end
    end

    assign S1    = req_vec[0];
    assign S2    = req_vec[1];
    assign S3    = req_vec[2];
    assign Stuck = stuck_vec;
    assign Fault = fault_q;

endmodule
